// File: rtl/avalon_pio_pkg.sv
// Shared constants for the Avalon-MM PIO/GPIO block: register map and edge-capture modes.
package avalon_pio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    localparam int unsigned EDGE_RISING  = 0;
    localparam int unsigned EDGE_FALLING = 1;
    localparam int unsigned EDGE_ANY     = 2;

endpackage

// File: rtl/avalon_pio_gpio_if.sv
// Avalon-MM slave bus bundle for the PIO block (zero-wait-state reads, no waitrequest).
interface avalon_pio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pio_input_sync.sv
// Pin synchroniser, delay stage and per-bit edge detector, disarmed for a few cycles after reset.
module pio_input_sync
    import avalon_pio_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned EDGE_TYPE = EDGE_RISING
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] edge_det
);

    logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;
    logic [1:0]       arm_q;
    logic             armed;
    logic [WIDTH-1:0] raw_edge;

    assign armed = (arm_q == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            arm_q   <= 2'd0;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (!armed) arm_q <= arm_q + 2'd1;
        end
    end

    always_comb begin
        raw_edge = sync2_q & ~prev_q;
        if (EDGE_TYPE == EDGE_FALLING) raw_edge = ~sync2_q & prev_q;
        else if (EDGE_TYPE == EDGE_ANY) raw_edge = sync2_q ^ prev_q;
    end

    // Suppresses the spurious edges seen while the pipeline fills with pins already high.
    assign edge_det = armed ? raw_edge : '0;
    assign sync_in  = sync2_q;

endmodule

// File: rtl/avalon_pio_gpio.sv
// Avalon-MM GPIO: data/direction/mask registers, set/clear aliases and W1C edge capture with irq.
module avalon_pio_gpio
    import avalon_pio_pkg::*;
#(
    parameter int unsigned     WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned     EDGE_TYPE   = EDGE_RISING
) (
    input  logic             clk,
    input  logic             reset,
    avalon_pio_if.slave      bus,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] oe_q, oe_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] sync_in, edge_det, wdata;
    logic [31:0]      rd_data;
    logic             wr_en;

    pio_input_sync #(
        .WIDTH     (WIDTH),
        .EDGE_TYPE (EDGE_TYPE)
    ) u_input_sync (
        .clk      (clk),
        .reset    (reset),
        .in_port  (in_port),
        .sync_in  (sync_in),
        .edge_det (edge_det)
    );

    assign wr_en = bus.chipselect & ~bus.write_n;
    assign wdata = bus.writedata[WIDTH-1:0];

    always_comb begin
        data_d = data_q;
        oe_d   = oe_q;
        mask_d = mask_q;
        cap_d  = cap_q;
        if (wr_en) begin
            case (bus.address)
                ADDR_DATA:    data_d = wdata;
                ADDR_DIR:     oe_d   = wdata;
                ADDR_IRQMASK: mask_d = wdata;
                ADDR_EDGECAP: cap_d  = cap_q & ~wdata;
                ADDR_OUTSET:  data_d = data_q | wdata;
                ADDR_OUTCLR:  data_d = data_q & ~wdata;
                default:      ;
            endcase
        end
        // OR-in after the clear so a fresh edge survives a concurrent W1C.
        cap_d = cap_d | edge_det;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= RESET_VALUE;
            oe_q   <= '0;
            mask_q <= '0;
            cap_q  <= '0;
        end else begin
            data_q <= data_d;
            oe_q   <= oe_d;
            mask_q <= mask_d;
            cap_q  <= cap_d;
        end
    end

    always_comb begin
        rd_data = '0;
        case (bus.address)
            ADDR_DATA:    rd_data[WIDTH-1:0] = (data_q & oe_q) | (sync_in & ~oe_q);
            ADDR_DIR:     rd_data[WIDTH-1:0] = oe_q;
            ADDR_IRQMASK: rd_data[WIDTH-1:0] = mask_q;
            ADDR_EDGECAP: rd_data[WIDTH-1:0] = cap_q;
            default:      ;
        endcase
    end

    assign bus.readdata = rd_data;
    assign out_port     = data_q;
    assign oe           = oe_q;
    assign irq          = |(cap_q & mask_q);

endmodule

// File: doc/avalon_pio_gpio.md
AVALON_PIO_GPIO -- requirements
Module: avalon_pio_gpio

Interface
REQ-001 Parameter WIDTH, default 8, number of GPIO bits (legal 1..32).
REQ-002 Parameter RESET_VALUE, default 0, reset value of the output data register (WIDTH bits).
REQ-003 Parameter EDGE_TYPE, default 0, edge-capture mode: 0 rising, 1 falling, 2 any.
REQ-004 Port clk  input  1  sole clock; all state on its rising edge.
REQ-005 Port reset  input  1  reset, asynchronous and active-high.
REQ-006 Port address  input  3  Avalon-MM slave word address.
REQ-007 Port chipselect  input  1  slave select.
REQ-008 Port write_n  input  1  active-low write strobe.
REQ-009 Port writedata  input  32  write data; bits above WIDTH-1 ignored.
REQ-010 Port readdata  output  32  combinational read data, zero wait states; bits above WIDTH-1 are 0.
REQ-011 Port in_port  input  WIDTH  asynchronous pin inputs.
REQ-012 Port out_port  output  WIDTH  output data register.
REQ-013 Port oe  output  WIDTH  per-bit output enable (direction register).
REQ-014 Port irq  output  1  level interrupt request.

Function
REQ-015 Write occurs on a clk edge when chipselect=1 and write_n=0; only the addressed register changes.
REQ-016 Address 0 (DATA): write loads data_out; read returns, per bit, data_out where oe=1 else the synchronised input.
REQ-017 Address 1 (DIR): read/write oe; 1 = output.
REQ-018 Address 2 (IRQMASK): read/write irq_mask.
REQ-019 Address 3 (EDGECAP): read returns edge_capture; write clears each bit written as 1 (W1C).
REQ-020 Address 4 (OUTSET): write ORs writedata into data_out; read returns 0.
REQ-021 Address 5 (OUTCLR): write clears data_out bits written as 1; read returns 0.
REQ-022 Addresses 6-7: writes ignored, reads return 0.
REQ-023 in_port passes through a 2-FF synchroniser (sync1, sync2) then a delay stage prev.
REQ-024 Edge detected per bit: rising sync2&~prev, falling ~sync2&prev, any sync2^prev, per EDGE_TYPE.
REQ-025 Detected edge sets edge_capture bit on the next clk edge; an in_port change set up before edge k is visible in edge_capture after edge k+2.
REQ-026 Simultaneous W1C and new edge on the same bit: set wins.
REQ-027 irq = |(edge_capture & irq_mask), combinational from registers, no additional latency.
REQ-028 Edge capture disarmed after reset: 2-bit arm counter counts 0..3 from reset release and saturates; edges are ignored while counter < 3, so pins already high at reset cause no capture.
REQ-029 Edge capture operates regardless of oe.

Reset
REQ-030 On reset: data_out=RESET_VALUE, oe=0, irq_mask=0, edge_capture=0, sync1/sync2/prev=0, arm counter=0; hence out_port=RESET_VALUE, oe=0, irq=0.
REQ-031 Reset asserted mid-operation takes effect immediately (asynchronous) and overrides any concurrent write.

Structure
REQ-032 Shared package avalon_pio_pkg holds address constants (ADDR_DATA..ADDR_OUTCLR) and EDGE_RISING/EDGE_FALLING/EDGE_ANY encodings.
REQ-033 One sub-module pio_input_sync (WIDTH-parametrised synchroniser, prev stage, edge detect, arm counter) instantiated once.

Verification (WIDTH=8, EDGE_TYPE=0 unless stated)
REQ-034 Reset, then write DATA=0xA5, OUTSET=0x0A, OUTCLR=0x81 -> out_port 0xA5, 0xAF, 0x2E; DIR=0xFF read DATA=0x2E.
REQ-035 in_port 0x00->0x01 at cycle k with irq_mask=0x01 -> EDGECAP=0x01 and irq=1 after edge k+2; write EDGECAP=0x01 -> irq=0.
REQ-036 W1C to bit 0 in same cycle a new rising edge on bit 0 is detected -> EDGECAP bit 0 remains 1.
REQ-037 in_port=0xFF held through reset release -> EDGECAP stays 0x00 for 10 cycles.
REQ-038 EDGE_TYPE=2, toggle bit 3 high then low, clearing EDGECAP between -> EDGECAP=0x08 after each transition; irq_mask=0 -> irq stays 0.
REQ-039 Read address 6 and 7 -> readdata 0x00000000; reset asserted mid-write to DATA -> out_port=RESET_VALUE.
